// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: instruction fetch sequencer for the 16-bit CPU.
// Owns the program counter, issues one BRAM read per fetch, waits MEM_LAT
// cycles for the data and presents the word to decode on a valid/ready
// handshake. A jump request redirects the PC. Any read that is in flight when
// the jump arrives is dropped through the squash flag.
// Optional feature: define FETCH_HALT_EN to add the HALTED state and the
// 'halted' output. When the accepted word is 16'hFFFF, fetch stops until a jump.
module pc_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_req,
  input  logic [15:0] jump_target,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] pc
`ifdef FETCH_HALT_EN
  , output logic      halted
`endif
);

  // Value loaded into the latency counter when a read is issued.
  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT);

  typedef enum logic [2:0] {
    ST_BOOT    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3
`ifdef FETCH_HALT_EN
    , ST_HALTED = 3'd4
`endif
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] pc_r, pc_s;
  logic [15:0] pc_inc_s;
  logic        mem_rd_r, mem_rd_s;
  logic [15:0] mem_addr_r, mem_addr_s;
  logic [15:0] instr_r, instr_s;
  logic [15:0] instr_pc_r, instr_pc_s;
  logic        instr_valid_r, instr_valid_s;
  logic [1:0]  lat_cnt_r, lat_cnt_s;
  logic        squash_r, squash_s;
`ifdef FETCH_HALT_EN
  logic        halted_r, halted_s;
`endif

  // Sequential PC; wraps from 16'hFFFF to 16'h0000 with no flag.
  assign pc_inc_s = pc_r + 16'd1;

  // Next-state, next-PC and next-output logic. Every registered output
  // is computed here one cycle ahead, so mem_rd is high during the ISSUE cycle.
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    mem_rd_s      = 1'b0;
    mem_addr_s    = mem_addr_r;
    instr_s       = instr_r;
    instr_pc_s    = instr_pc_r;
    instr_valid_s = instr_valid_r;
    lat_cnt_s     = lat_cnt_r;
    squash_s      = squash_r;
`ifdef FETCH_HALT_EN
    halted_s      = halted_r;
`endif

    case (state_r)
      ST_BOOT: begin
        // A jump during the idle cycle retargets the very first fetch.
        if (jump_req) begin
          pc_s = jump_target;
        end else begin
          pc_s = pc_r;
        end
        state_s = ST_ISSUE;
      end

      ST_ISSUE: begin
        lat_cnt_s = LAT_INIT;
        state_s   = ST_WAIT;
        // The read is already on the bus; mark it for dropping.
        if (jump_req) begin
          pc_s     = jump_target;
          squash_s = 1'b1;
        end else begin
          pc_s     = pc_r;
        end
      end

      ST_WAIT: begin
        lat_cnt_s = lat_cnt_r - 2'd1;
        if (lat_cnt_r == 2'd1) begin
          // Read data is on mem_rdata in this cycle.
          if (jump_req || squash_r) begin
            if (jump_req) begin
              pc_s = jump_target;
            end else begin
              pc_s = pc_r;
            end
            squash_s = 1'b0;
            state_s  = ST_ISSUE;
          end else begin
            instr_s       = mem_rdata;
            instr_pc_s    = pc_r;
            instr_valid_s = 1'b1;
            state_s       = ST_PRESENT;
          end
        end else begin
          // A jump in an earlier WAIT cycle still lets the read finish, then drops it.
          if (jump_req) begin
            pc_s     = jump_target;
            squash_s = 1'b1;
          end else begin
            pc_s     = pc_r;
          end
        end
      end

      ST_PRESENT: begin
        // A jump wins over a same-cycle accept. The held word is discarded.
        if (jump_req) begin
          pc_s          = jump_target;
          instr_valid_s = 1'b0;
          state_s       = ST_ISSUE;
        end else if (instr_ready) begin
          pc_s          = pc_inc_s;
          instr_valid_s = 1'b0;
`ifdef FETCH_HALT_EN
          if (instr_r == 16'hFFFF) begin
            halted_s = 1'b1;
            state_s  = ST_HALTED;
          end else begin
            state_s  = ST_ISSUE;
          end
`else
          state_s       = ST_ISSUE;
`endif
        end else begin
          state_s = ST_PRESENT;
        end
      end

`ifdef FETCH_HALT_EN
      ST_HALTED: begin
        // PC stays at the HALT address + 1. Only a jump or reset leaves this state.
        if (jump_req) begin
          pc_s     = jump_target;
          halted_s = 1'b0;
          state_s  = ST_ISSUE;
        end else begin
          state_s  = ST_HALTED;
        end
      end
`endif

      default: begin
        state_s       = ST_BOOT;
        instr_valid_s = 1'b0;
        squash_s      = 1'b0;
        lat_cnt_s     = 2'd0;
      end
    endcase

    // Raise the strobe for exactly the ISSUE cycle, addressed by the PC in force then.
    if (state_s == ST_ISSUE) begin
      mem_rd_s   = 1'b1;
      mem_addr_s = pc_s;
    end else begin
      mem_rd_s   = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_BOOT;
      pc_r          <= RESET_PC;
      mem_rd_r      <= 1'b0;
      mem_addr_r    <= 16'h0000;
      instr_r       <= 16'h0000;
      instr_pc_r    <= 16'h0000;
      instr_valid_r <= 1'b0;
      lat_cnt_r     <= 2'd0;
      squash_r      <= 1'b0;
`ifdef FETCH_HALT_EN
      halted_r      <= 1'b0;
`endif
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      mem_rd_r      <= mem_rd_s;
      mem_addr_r    <= mem_addr_s;
      instr_r       <= instr_s;
      instr_pc_r    <= instr_pc_s;
      instr_valid_r <= instr_valid_s;
      lat_cnt_r     <= lat_cnt_s;
      squash_r      <= squash_s;
`ifdef FETCH_HALT_EN
      halted_r      <= halted_s;
`endif
    end
  end

  assign mem_rd      = mem_rd_r;
  assign mem_addr    = mem_addr_r;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign instr_valid = instr_valid_r;
  assign pc          = pc_r;
`ifdef FETCH_HALT_EN
  assign halted      = halted_r;
`endif

endmodule
